// File: rtl/packet_source_buffer_pkg.sv
// Shared NoC package (noc_pkg): flit field widths, the packet_t flit layout,
// the stored-entry layout, the packet source FSM state type and the flit
// packing helper. The output buffer unpacks flits with the same packet_t.
package noc_pkg;

  localparam int unsigned WIDTH_packet = 28;
  localparam int unsigned WIDTH_addr   = 3;
  localparam int unsigned WIDTH_dest   = 3;
  localparam int unsigned WIDTH        = WIDTH_packet + WIDTH_addr + WIDTH_dest;

  // Flit layout, MSB first: {data, addr, dest}
  typedef struct packed {
    logic [WIDTH_packet-1:0] data;
    logic [WIDTH_addr-1:0]   addr;
    logic [WIDTH_dest-1:0]   dest;
  } packet_t;

  // One stored word; the source address is constant and not stored
  typedef struct packed {
    logic [WIDTH_packet-1:0] data;
    logic [WIDTH_dest-1:0]   dest;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } src_state_e;

  function automatic logic [WIDTH-1:0] pack_flit(
    input logic [WIDTH_packet-1:0] data,
    input logic [WIDTH_addr-1:0]   addr,
    input logic [WIDTH_dest-1:0]   dest
  );
    packet_t p;
    p.data = data;
    p.addr = addr;
    p.dest = dest;
    return p;
  endfunction

endpackage

// File: rtl/packet_source_buffer_if.sv
// Loader/transmit bundle of the packet source buffer.
//   master : the loader / test side (drives writes, start and tx_ready)
//   slave  : the packet_source_buffer itself
// Signals: wr_en/wr_data/wr_dest/wr_ready load port, start pulse,
// tx_valid/tx_ready/tx_packet injection link, busy/done/sent_count/overflow status.
interface packet_source_buffer_if
  import noc_pkg::*;
#(
  parameter int unsigned CNT_W = 5
) ();

  logic                    wr_en;
  logic [WIDTH_packet-1:0] wr_data;
  logic [WIDTH_dest-1:0]   wr_dest;
  logic                    wr_ready;
  logic                    start;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [WIDTH-1:0]        tx_packet;
  logic                    busy;
  logic                    done;
  logic [CNT_W-1:0]        sent_count;
  logic                    overflow;

  modport master (
    output wr_en, wr_data, wr_dest, start, tx_ready,
    input  wr_ready, tx_valid, tx_packet, busy, done, sent_count, overflow
  );

  modport slave (
    input  wr_en, wr_data, wr_dest, start, tx_ready,
    output wr_ready, tx_valid, tx_packet, busy, done, sent_count, overflow
  );

endinterface

// File: rtl/packet_source_buffer_pkt_store.sv
// pkt_store: DEPTH x entry_t register file for the packet source buffer.
// Ports: clk_i clock; we_i/waddr_i/wdata_i synchronous write port;
// raddr_i/rdata_o asynchronous read port.
module pkt_store
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH = 20,
  parameter int unsigned AW    = 5
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  entry_t        wdata_i,
  input  logic [AW-1:0] raddr_i,
  output entry_t        rdata_o
);

  entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/packet_source_buffer.sv
// packet_source_buffer: injection endpoint of the tree NoC. Stores up to
// NUM_PACKETS {data,dest} words and, on start, sends them in write order as
// {data, SRC_ADDR, dest} flits over a valid/ready link.
// Ports: clk, rst_n (async active-low); bus (slave modport) carrying the load
// port, start, the tx valid/ready link and busy/done/sent_count/overflow.
module packet_source_buffer
  import noc_pkg::*;
#(
  parameter int unsigned NUM_PACKETS = 20,
  parameter int unsigned SRC_ADDR    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  packet_source_buffer_if.slave bus
);

  localparam int unsigned CW = $clog2(NUM_PACKETS + 1);
  localparam logic [WIDTH_addr-1:0] SRC_F = WIDTH_addr'(SRC_ADDR);
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM_PACKETS);

  // Reset asserts asynchronously, releases two clocks after rst_n rises
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  src_state_e      state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic            overflow_q, overflow_d;

  logic            wr_acc;
  logic            fire;
  logic            last;
  logic            load_state;
  entry_t          wr_entry;
  entry_t          rd_entry;

  assign load_state = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign wr_acc     = bus.wr_en && bus.wr_ready;
  assign fire       = bus.tx_valid && bus.tx_ready;
  assign last       = (rd_ptr_q == count_q - CW'(1));
  assign wr_entry   = '{data: bus.wr_data, dest: bus.wr_dest};

  pkt_store #(
    .DEPTH (NUM_PACKETS),
    .AW    (CW)
  ) u_store (
    .clk_i   (clk),
    .we_i    (wr_acc),
    .waddr_i (count_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry)
  );

  // State register
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. A write coinciding with start is part of the transmission,
  // so the empty test uses the post-write count.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ((count_q != '0) || wr_acc) ? ST_SEND : ST_DONE;
        end else if (wr_acc) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (fire && last) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs. tx_valid/tx_packet decode the state register directly so an
  // async reset drops them immediately; rd_ptr is frozen while stalled, which
  // keeps tx_packet bit-stable.
  always_comb begin
    bus.tx_valid   = (state_q == ST_SEND);
    bus.busy       = (state_q == ST_SEND);
    bus.done       = (state_q == ST_DONE);
    bus.wr_ready   = load_state && (count_q < CNT_MAX);
    bus.tx_packet  = '0;
    if (state_q == ST_SEND) begin
      bus.tx_packet = pack_flit(rd_entry.data, SRC_F, rd_entry.dest);
    end
    bus.sent_count = sent_q;
    bus.overflow   = overflow_q;
  end

  // Counters and pointers
  always_comb begin
    count_d    = wr_acc ? count_q + CW'(1) : count_q;
    rd_ptr_d   = rd_ptr_q;
    sent_d     = sent_q;
    overflow_d = overflow_q | (bus.wr_en & ~bus.wr_ready);
    if (load_state && bus.start) begin
      rd_ptr_d = '0;
      sent_d   = '0;
    end else if ((state_q == ST_SEND) && fire) begin
      rd_ptr_d = rd_ptr_q + CW'(1);
      sent_d   = sent_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      count_q    <= '0;
      rd_ptr_q   <= '0;
      sent_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      sent_q     <= sent_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
